// File: rtl/ccip_c1arb_pkg.sv
// Shared types and constants for the CCI-P c1Tx write arbiter.
// Holds the channel widths, the arbiter state enum and the mdata tag layout.
package ccip_c1arb_pkg;

    localparam int CCIP_C1TX_HDR_WIDTH = 80;
    localparam int CCIP_C1RX_HDR_WIDTH = 28;
    localparam int CCIP_CLDATA_WIDTH   = 512;

    // Requester index lives in the top IDW bits of the 16-bit mdata field.
    localparam int C1ARB_TAG_HI = 15;

    typedef enum logic [1:0] {
        C1ARB_RUN   = 2'd0,
        C1ARB_DRAIN = 2'd1,
        C1ARB_IDLE  = 2'd2
    } t_c1arb_state;

    function automatic int c1arb_idw(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/ccip_rr_arbiter.sv
// Round-robin one-hot selector: the first requester at or after ptr wins,
// wrapping from N-1 back to 0.
module ccip_rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [PW:0] pos;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant = '0;
        pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (PW + 1)'(k);
            if (pos >= (PW + 1)'(N)) begin
                pos = pos - (PW + 1)'(N);
            end
            if (req[pos[PW-1:0]]) begin
                grant                = '0;
                grant[pos[PW-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ccip_c1tx_arbiter.sv
// Round-robin arbiter sharing one CCI-P c1Tx write channel among NUM_REQ requesters,
// with per-requester outstanding caps, response routing and a drain handshake.
// Optional statistics counters are built when C1TX_ARB_STATS_EN is defined.
module ccip_c1tx_arbiter
    import ccip_c1arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                                   pClk,
    input  logic                                   pck_cp2af_softReset_n,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ*CCIP_C1TX_HDR_WIDTH-1:0] req_hdr,
    input  logic [NUM_REQ*CCIP_CLDATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic                                   c1TxAlmFull,
    output logic [CCIP_C1TX_HDR_WIDTH-1:0]         c1Tx_hdr,
    output logic [CCIP_CLDATA_WIDTH-1:0]           c1Tx_data,
    output logic                                   c1Tx_valid,
    input  logic [CCIP_C1RX_HDR_WIDTH-1:0]         c1Rx_hdr,
    input  logic                                   c1Rx_rspValid,
    output logic [NUM_REQ-1:0]                     rsp_valid,
    input  logic                                   drain_req,
    output logic                                   drain_done
`ifdef C1TX_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]                  grant_count,
    output logic [31:0]                            almfull_stall
`endif
);

    localparam int IDW = c1arb_idw(NUM_REQ);
    localparam int CW  = $clog2(MAX_OUTSTANDING) + 1;

    t_c1arb_state state_reg, state_next;

    logic [IDW-1:0]                 ptr_reg, ptr_next;
    logic [NUM_REQ-1:0]             eligible, grant, rsp_hit, cnt_zero_next;
    logic [NUM_REQ-1:0]             rsp_valid_reg;
    logic                           grant_any;
    logic [IDW-1:0]                 grant_idx;
    logic [IDW-1:0]                 rsp_idx;
    logic [CCIP_C1TX_HDR_WIDTH-1:0] hdr_sel, c1tx_hdr_reg;
    logic [CCIP_CLDATA_WIDTH-1:0]   data_sel, c1tx_data_reg;
    logic                           c1tx_valid_reg;
    logic                           unused_rx_bits;

    assign rsp_idx        = c1Rx_hdr[C1ARB_TAG_HI -: IDW];
    assign unused_rx_bits = ^c1Rx_hdr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [CW-1:0] cnt_reg, cnt_next;

            assign rsp_hit[gi]  = c1Rx_rspValid && (rsp_idx == IDW'(gi));
            assign eligible[gi] = req_valid[gi] && !c1TxAlmFull
                                  && (cnt_reg < CW'(MAX_OUTSTANDING))
                                  && (state_reg == C1ARB_RUN);

            // Grant and response in the same cycle cancel; a stray response saturates at 0.
            always_comb begin
                cnt_next = cnt_reg;
                if (grant[gi] && !rsp_hit[gi]) begin
                    cnt_next = cnt_reg + CW'(1);
                end else if (rsp_hit[gi] && !grant[gi] && (cnt_reg != '0)) begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end

            assign cnt_zero_next[gi] = (cnt_next == '0);

            always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
                if (!pck_cp2af_softReset_n) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
        end
    endgenerate

    ccip_rr_arbiter #(
        .N  (NUM_REQ),
        .PW (IDW)
    ) u_rr (
        .req   (eligible),
        .ptr   (ptr_reg),
        .grant (grant)
    );

    assign grant_any = |grant;
    assign req_ready = grant;

    always_comb begin
        grant_idx = '0;
        hdr_sel   = '0;
        data_sel  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = IDW'(i);
                hdr_sel   = req_hdr[i*CCIP_C1TX_HDR_WIDTH +: CCIP_C1TX_HDR_WIDTH];
                data_sel  = req_data[i*CCIP_CLDATA_WIDTH +: CCIP_CLDATA_WIDTH];
            end
        end
        hdr_sel[C1ARB_TAG_HI -: IDW] = grant_idx;
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_any) begin
            ptr_next = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
        end
    end

    // State register
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            state_reg <= C1ARB_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: drain completion looks at post-edge counts so drain_done
    // rises together with the last response pulse.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            C1ARB_RUN:   if (drain_req) state_next = C1ARB_DRAIN;
            C1ARB_DRAIN: if ((&cnt_zero_next) && !grant_any) state_next = C1ARB_IDLE;
            C1ARB_IDLE:  if (!drain_req) state_next = C1ARB_RUN;
            default:     state_next = C1ARB_RUN;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        drain_done = (state_reg == C1ARB_IDLE);
    end

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            ptr_reg        <= '0;
            c1tx_valid_reg <= 1'b0;
            rsp_valid_reg  <= '0;
        end else begin
            ptr_reg        <= ptr_next;
            c1tx_valid_reg <= grant_any;
            rsp_valid_reg  <= rsp_hit;
        end
    end

    always_ff @(posedge pClk) begin
        if (grant_any) begin
            c1tx_hdr_reg  <= hdr_sel;
            c1tx_data_reg <= data_sel;
        end
    end

    assign c1Tx_valid = c1tx_valid_reg;
    assign c1Tx_hdr   = c1tx_hdr_reg;
    assign c1Tx_data  = c1tx_data_reg;
    assign rsp_valid  = rsp_valid_reg;

`ifdef C1TX_ARB_STATS_EN
    logic [31:0] stall_reg;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_stat
            logic [31:0] gcnt_reg;

            always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
                if (!pck_cp2af_softReset_n) begin
                    gcnt_reg <= '0;
                end else if (grant[gi]) begin
                    gcnt_reg <= gcnt_reg + 32'd1;
                end
            end

            assign grant_count[gi*32 +: 32] = gcnt_reg;
        end
    endgenerate

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            stall_reg <= '0;
        end else if ((|req_valid) && c1TxAlmFull) begin
            stall_reg <= stall_reg + 32'd1;
        end
    end

    assign almfull_stall = stall_reg;
`endif

endmodule

// File: tb/tb_ccip_c1tx_arbiter.sv
// Randomized and directed bench for ccip_c1tx_arbiter against a queue/array
// reference model of the grant, tag, response and drain rules.
module tb_ccip_c1tx_arbiter;
    import ccip_c1arb_pkg::*;

    localparam int N    = 4;
    localparam int MAXO = 4;
    localparam int HW   = CCIP_C1TX_HDR_WIDTH;
    localparam int DW   = CCIP_CLDATA_WIDTH;
    localparam int RW   = CCIP_C1RX_HDR_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N*HW-1:0] req_hdr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic          c1TxAlmFull = 1'b0;
    logic [HW-1:0] c1Tx_hdr;
    logic [DW-1:0] c1Tx_data;
    logic          c1Tx_valid;
    logic [RW-1:0] c1Rx_hdr = '0;
    logic          c1Rx_rspValid = 1'b0;
    logic [N-1:0]  rsp_valid;
    logic          drain_req = 1'b0;
    logic          drain_done;
`ifdef C1TX_ARB_STATS_EN
    logic [N*32-1:0] grant_count;
    logic [31:0]     almfull_stall;
`endif

    always #5 clk = ~clk;

    ccip_c1tx_arbiter #(
        .NUM_REQ         (N),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .pClk                  (clk),
        .pck_cp2af_softReset_n (rst_n),
        .req_valid             (req_valid),
        .req_hdr               (req_hdr),
        .req_data              (req_data),
        .req_ready             (req_ready),
        .c1TxAlmFull           (c1TxAlmFull),
        .c1Tx_hdr              (c1Tx_hdr),
        .c1Tx_data             (c1Tx_data),
        .c1Tx_valid            (c1Tx_valid),
        .c1Rx_hdr              (c1Rx_hdr),
        .c1Rx_rspValid         (c1Rx_rspValid),
        .rsp_valid             (rsp_valid),
        .drain_req             (drain_req),
        .drain_done            (drain_done)
`ifdef C1TX_ARB_STATS_EN
        ,
        .grant_count           (grant_count),
        .almfull_stall         (almfull_stall)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding counts, next search start, mode (0 run, 1 drain, 2 idle)
    int m_cnt[N];
    int m_ptr;
    int m_mode;

    int            p_gnt;
    logic          p_valid;
    logic [HW-1:0] p_hdr;
    logic [DW-1:0] p_data;
    logic [N-1:0]  p_rsp;
    logic          p_done;

    int   gnt_log[$];
    int   vcnt;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_ptr  = 0;
        m_mode = 0;
    endtask

    task automatic predict();
        int ridx;
        int all_zero;
        p_gnt = -1;
        if (m_mode == 0 && !c1TxAlmFull) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (p_gnt < 0 && req_valid[i] && m_cnt[i] < MAXO) p_gnt = i;
            end
        end
        p_valid = (p_gnt >= 0);
        if (p_valid) begin
            logic [1:0] tag;
            tag    = 2'(p_gnt);
            p_hdr  = req_hdr[p_gnt*HW +: HW];
            p_hdr[15:14] = tag;
            p_data = req_data[p_gnt*DW +: DW];
            m_ptr  = (p_gnt + 1) % N;
        end
        ridx  = int'(c1Rx_hdr[15:14]);
        p_rsp = c1Rx_rspValid ? N'(1 << ridx) : '0;
        for (int i = 0; i < N; i++) begin
            int inc, dec;
            inc = (p_gnt == i);
            dec = (c1Rx_rspValid && ridx == i);
            if (inc && !dec) m_cnt[i] = m_cnt[i] + 1;
            else if (dec && !inc && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
        end
        all_zero = 1;
        for (int i = 0; i < N; i++) if (m_cnt[i] != 0) all_zero = 0;
        case (m_mode)
            0: if (drain_req) m_mode = 1;
            1: if (all_zero) m_mode = 2;
            default: if (!drain_req) m_mode = 0;
        endcase
        p_done = (m_mode == 2);
    endtask

    task automatic drive(input logic [N-1:0] v, input logic alm, input logic rv, input int ridx);
        logic [1:0] tag;
        req_valid   = v;
        c1TxAlmFull = alm;
        for (int i = 0; i < N; i++) begin
            logic [95:0] h;
            h = {$urandom, $urandom, $urandom};
            req_hdr[i*HW +: HW] = h[HW-1:0];
            for (int k = 0; k < DW / 32; k++) req_data[i*DW + k*32 +: 32] = $urandom;
        end
        tag           = 2'(ridx);
        c1Rx_rspValid = rv;
        c1Rx_hdr      = RW'($urandom);
        c1Rx_hdr[15:14] = tag;
    endtask

    task automatic cycle();
        logic [N-1:0] er;
        int dut_g;
        @(negedge clk);
        predict();
        er = p_valid ? N'(1 << p_gnt) : '0;
        check("req_ready", DW'(req_ready), DW'(er));
        dut_g = -1;
        for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) dut_g = i;
        if (dut_g >= 0) gnt_log.push_back(dut_g);
        @(posedge clk);
        #1;
        check("c1Tx_valid", DW'(c1Tx_valid), DW'(p_valid));
        if (p_valid) begin
            check("c1Tx_hdr", DW'(c1Tx_hdr), DW'(p_hdr));
            check("c1Tx_data", c1Tx_data, p_data);
            $display("tx req=%0d tag=%0d t=%0t", p_gnt, c1Tx_hdr[15:14], $time);
        end
        if (c1Tx_valid) vcnt++;
        check("rsp_valid", DW'(rsp_valid), DW'(p_rsp));
        if (|p_rsp) $display("rsp vec=%b t=%0t", rsp_valid, $time);
        check("drain_done", DW'(drain_done), DW'(p_done));
    endtask

    task automatic return_all();
        for (int g = 0; g < 64; g++) begin
            int idx;
            idx = -1;
            for (int i = N - 1; i >= 0; i--) if (m_cnt[i] > 0) idx = i;
            if (idx < 0) break;
            drive('0, 1'b0, 1'b1, idx);
            cycle();
        end
        drive('0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ng;
        model_reset();
        // Reset state
        #12;
        check("reset_c1Tx_valid", DW'(c1Tx_valid), DW'(0));
        check("reset_rsp_valid", DW'(rsp_valid), DW'(0));
        check("reset_drain_done", DW'(drain_done), DW'(0));
        check("reset_req_ready", DW'(req_ready), DW'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive('0, 1'b0, 1'b0, 0);
        cycle();

        // Fairness: all four requesting for eight cycles
        gnt_log.delete();
        vcnt = 0;
        for (int c = 0; c < 8; c++) begin
            drive(4'b1111, 1'b0, 1'b0, 0);
            cycle();
        end
        for (int c = 0; c < 8; c++)
            check("fair_order", DW'(c < gnt_log.size() ? gnt_log[c] : -1), DW'(c % 4));
        check("fair_valid_run", DW'(vcnt), DW'(8));
        return_all();

        // Back-pressure on cycles 3..6
        for (int c = 0; c < 10; c++) begin
            drive(4'b1111, (c >= 3 && c <= 6), 1'b0, 0);
            cycle();
        end
        return_all();

        // Outstanding cap on requester 1
        gnt_log.delete();
        for (int c = 0; c < 6; c++) begin
            drive(4'b0010, 1'b0, 1'b0, 0);
            cycle();
        end
        check("cap_grants", DW'(gnt_log.size()), DW'(4));
        drive(4'b0010, 1'b0, 1'b1, 1);
        cycle();
        for (int c = 0; c < 3; c++) begin
            drive(4'b0010, 1'b0, 1'b0, 0);
            cycle();
        end
        check("cap_regrant", DW'(gnt_log.size()), DW'(5));
        return_all();

        // Response routing, including a stray response that must saturate
        drive(4'b0100, 1'b0, 1'b0, 0);
        cycle();
        drive('0, 1'b0, 1'b1, 2);
        cycle();
        check("route_rsp2", DW'(rsp_valid), DW'(4'b0100));
        drive('0, 1'b0, 1'b1, 3);
        cycle();
        check("stray_rsp3", DW'(rsp_valid), DW'(4'b1000));

        // Drain with three writes outstanding
        for (int c = 0; c < 3; c++) begin
            drive(4'b0111, 1'b0, 1'b0, 0);
            cycle();
        end
        drain_req = 1'b1;
        drive('0, 1'b0, 1'b0, 0);
        cycle();
        gnt_log.delete();
        for (int r = 0; r < 3; r++) begin
            drive(4'b1111, 1'b0, 1'b0, 0);
            cycle();
            drive(4'b1111, 1'b0, 1'b1, r);
            cycle();
        end
        check("drain_no_grants", DW'(gnt_log.size()), DW'(0));
        check("drain_done_set", DW'(drain_done), DW'(1));
        drain_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(4'b1111, 1'b0, 1'b0, 0);
            cycle();
        end
        check("drain_resume", DW'(gnt_log.size() > 0), DW'(1));
        return_all();

        // Randomized traffic
        for (int c = 0; c < 300; c++) begin
            int ridx;
            logic rv;
            if ($urandom_range(0, 99) < 3) drain_req = ~drain_req;
            ridx = -1;
            for (int k = 0; k < N; k++) begin
                int i;
                i = (c + k) % N;
                if (ridx < 0 && m_cnt[i] > 0) ridx = i;
            end
            if (ridx < 0 || $urandom_range(0, 9) == 0) ridx = $urandom_range(0, N - 1);
            rv = ($urandom_range(0, 99) < 40);
            drive(N'($urandom), ($urandom_range(0, 99) < 20), rv, ridx);
            cycle();
        end
        drain_req = 1'b0;
        return_all();
        for (int c = 0; c < 3; c++) begin
            drive('0, 1'b0, 1'b0, 0);
            cycle();
        end

        // Reset in the middle of back-to-back grants
        for (int c = 0; c < 3; c++) begin
            drive(4'b1111, 1'b0, 1'b0, 0);
            cycle();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_c1Tx_valid", DW'(c1Tx_valid), DW'(0));
        check("midreset_rsp_valid", DW'(rsp_valid), DW'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        gnt_log.delete();
        drive(4'b1111, 1'b0, 1'b0, 0);
        cycle();
        ng = gnt_log.size();
        check("first_grant_after_reset", DW'(ng > 0 ? gnt_log[0] : -1), DW'(0));
        for (int c = 0; c < 3; c++) begin
            drive(4'b1111, 1'b0, 1'b0, 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccip_c1tx_arbiter.md
CCIP_C1TX_ARBITER -- requirements
Module: ccip_c1tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of write requesters (2..8).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 64: per-requester cap on un-acked writes (power of 2, up to 256).
REQ-003 SHALL have port pClk, input, 1: sole clock; all logic is on its rising edge.
REQ-004 SHALL have port pck_cp2af_softReset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, NUM_REQ: per-requester write request.
REQ-006 SHALL have port req_hdr, input, NUM_REQ*CCIP_C1TX_HDR_WIDTH: flat per-requester c1Tx headers.
REQ-007 SHALL have port req_data, input, NUM_REQ*CCIP_CLDATA_WIDTH: flat per-requester line data.
REQ-008 SHALL have port req_ready, output, NUM_REQ: one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-009 SHALL have port c1TxAlmFull, input, 1: channel back-pressure.
REQ-010 SHALL have ports c1Tx_hdr, c1Tx_data and c1Tx_valid, outputs, CCIP_C1TX_HDR_WIDTH, CCIP_CLDATA_WIDTH and 1: the shared write channel.
REQ-011 SHALL have ports c1Rx_hdr, input, CCIP_C1RX_HDR_WIDTH, and c1Rx_rspValid, input, 1: write responses.
REQ-012 SHALL have port rsp_valid, output, NUM_REQ: one-cycle pulse routing each response to its requester.
REQ-013 SHALL have ports drain_req, input, 1, and drain_done, output, 1: quiesce handshake.

Function
REQ-014 SHALL grant at most one requester per cycle, round-robin, starting the search at the index after the last grant.
REQ-015 SHALL make requester i eligible only when req_valid[i]=1, c1TxAlmFull=0, outstanding[i] is below MAX_OUTSTANDING, and the state is RUN.
REQ-016 SHALL drive req_ready combinationally from eligibility and the round-robin pointer; req_ready SHALL be 0 when no requester is eligible.
REQ-017 SHALL register the granted hdr and data, with c1Tx_valid=1 on the cycle after the handshake (latency 1), and c1Tx_valid=0 otherwise.
REQ-018 SHALL overwrite hdr mdata bits [15:16-IDW] with the requester index, where IDW=$clog2(NUM_REQ); all other header bits pass unchanged.
REQ-019 SHALL decode the index from c1Rx_hdr[15:16-IDW] when c1Rx_rspValid=1, pulse rsp_valid[index] the next cycle, and decrement outstanding[index].
REQ-020 SHALL increment outstanding[i] on each grant of requester i; a simultaneous grant and response for the same i SHALL leave the count unchanged.
REQ-021 SHALL treat a response arriving when outstanding=0 as a no-op that saturates at 0; rsp_valid still pulses.
REQ-022 SHALL implement the states RUN, DRAIN and IDLE:
- RUN -> DRAIN on drain_req=1.
- DRAIN makes no new grants; it goes to IDLE when every outstanding count is 0 and c1Tx_valid=0.
- IDLE drives drain_done=1 and goes back to RUN when drain_req=0.
REQ-023 SHALL wrap the round-robin pointer from NUM_REQ-1 to 0.

Reset
REQ-024 SHALL, on reset assertion, asynchronously clear the following: c1Tx_valid, rsp_valid, drain_done, all outstanding counts and the round-robin pointer (pointer reset value 0).
REQ-025 SHALL enter RUN on reset release; an in-flight grant SHALL be dropped and no response tracking SHALL be retained.

Configuration
REQ-026 SHALL, when C1TX_ARB_STATS_EN is defined, add output grant_count of width NUM_REQ*32: per-requester 32-bit wrapping grant counters plus a 32-bit almfull_stall counter, counting cycles with any req_valid=1 while c1TxAlmFull=1; all counters are cleared by reset.
REQ-027 SHALL, when C1TX_ARB_STATS_EN is not defined, omit these ports and counters entirely.

Structure
REQ-028 SHALL place the state enum t_c1arb_state, the IDW function and the mdata tag bit positions in package ccip_c1arb_pkg.
REQ-029 SHALL implement the round-robin selection in sub-module ccip_rr_arbiter (parameter N; inputs request vector and pointer; output one-hot grant).

Verification
REQ-030 SHALL cover fairness: all 4 requesters hold req_valid=1 for 8 cycles -> grants go 0,1,2,3,0,1,2,3 and c1Tx_valid is high on 8 consecutive cycles.
REQ-031 SHALL cover back-pressure: c1TxAlmFull=1 for cycles 3-6 -> req_ready=0 in cycles 3-6 and no c1Tx_valid in cycles 4-7.
REQ-032 SHALL cover the cap: MAX_OUTSTANDING=4, requester 1 alone with no responses -> exactly 4 grants, then req_ready[1]=0; one response with mdata tag 1 -> one further grant.
REQ-033 SHALL cover response routing: c1Rx_rspValid with mdata[15:14]=2 -> rsp_valid=4'b0100 one cycle later and outstanding[2] decrements.
REQ-034 SHALL cover drain: drain_req=1 with 3 writes outstanding -> no grants, then drain_done=1 one cycle after the third response; drain_req=0 -> grants resume.
REQ-035 SHALL cover mid-burst reset: reset asserted during back-to-back grants -> c1Tx_valid=0 immediately, and after release the first grant goes to requester 0.
